mxint_accum_arbiter: RTL and testbench



---
 rtl/mxint_accum_arbiter.sv | 144 ++++++++++++++
 tb/tb_mxint_accum_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mxint_accum_arbiter.sv
// mxint_accum_arbiter: time-shares one MxInt block accumulator between
// NUM_REQ requester streams. A grant is held for IN_DEPTH accepted beats,
// then the arbiter waits for the accumulator result handshake, tags the
// result with the owner ID and re-arbitrates.
// Optional build macro MXINT_ACCUM_ARB_FIXED_PRIO_EN: lowest-index valid
// requester always wins and rr_ptr stays at 0 (default: round-robin).
module mxint_accum_arbiter #(
    parameter int NUM_REQ               = 4,
    parameter int DATA_IN_0_PRECISION_0 = 8,
    parameter int DATA_IN_0_PRECISION_1 = 4,
    parameter int BLOCK_SIZE            = 4,
    parameter int IN_DEPTH              = 2,
    localparam int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_WIDTH = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1
) (
    input  logic                                                              clk,
    input  logic                                                              rst,
    input  logic [NUM_REQ-1:0][BLOCK_SIZE-1:0][DATA_IN_0_PRECISION_0-1:0]     req_mdata_in,
    input  logic [NUM_REQ-1:0][DATA_IN_0_PRECISION_1-1:0]                     req_edata_in,
    input  logic [NUM_REQ-1:0]                                                req_valid,
    output logic [NUM_REQ-1:0]                                                req_ready,
    output logic [BLOCK_SIZE-1:0][DATA_IN_0_PRECISION_0-1:0]                  acc_mdata,
    output logic [DATA_IN_0_PRECISION_1-1:0]                                  acc_edata,
    output logic                                                              acc_valid,
    input  logic                                                              acc_ready,
    input  logic                                                              acc_out_valid,
    input  logic                                                              acc_out_ready,
    output logic [ID_WIDTH-1:0]                                               result_id,
    output logic [ID_WIDTH-1:0]                                               grant_id,
    output logic                                                              busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        WAIT_OUT = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [ID_WIDTH-1:0]  rr_ptr, rr_n;
    logic [ID_WIDTH-1:0]  grant_n, result_n;
    logic [CNT_WIDTH-1:0] beat_cnt, beat_n;
    logic [ID_WIDTH-1:0]  pick_id, rr_next;
    logic [ID_WIDTH:0]    scan;
    logic                 pick_hit;
    logic                 streaming;
    logic                 beat_fire;
    logic                 last_beat;

    assign streaming = (state == STREAM);
    assign busy      = (state != IDLE);

    // Data path always follows the registered grant, so it is never X even
    // when acc_valid is low.
    assign acc_mdata = req_mdata_in[grant_id];
    assign acc_edata = req_edata_in[grant_id];
    assign acc_valid = streaming && req_valid[grant_id];

    assign beat_fire = acc_valid && acc_ready;
    assign last_beat = (beat_cnt == CNT_WIDTH'(IN_DEPTH - 1));
    assign rr_next   = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + ID_WIDTH'(1);

    // Per-lane ready depends only on state, grant and acc_ready; never on
    // another requester's valid.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign req_ready[i] = streaming && acc_ready && (grant_id == ID_WIDTH'(i));
    end

    // First valid requester scanning upward from rr_ptr with wrap-around.
    // In fixed-priority builds rr_ptr never leaves 0, so this is a plain
    // lowest-index pick.
    always_comb begin
        pick_hit = 1'b0;
        pick_id  = '0;
        scan     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr} + (ID_WIDTH + 1)'(k);
            if (scan >= (ID_WIDTH + 1)'(NUM_REQ))
                scan = scan - (ID_WIDTH + 1)'(NUM_REQ);
            if (!pick_hit && req_valid[scan[ID_WIDTH-1:0]]) begin
                pick_hit = 1'b1;
                pick_id  = scan[ID_WIDTH-1:0];
            end
        end
    end

    // Next-state and next-register logic for IDLE -> STREAM -> WAIT_OUT.
    always_comb begin
        state_n  = state;
        grant_n  = grant_id;
        beat_n   = beat_cnt;
        result_n = result_id;
        rr_n     = rr_ptr;
        case (state)
            IDLE: begin
                if (pick_hit) begin
                    grant_n = pick_id;
                    beat_n  = '0;
                    state_n = STREAM;
                end
            end
            STREAM: begin
                if (beat_fire) begin
                    if (last_beat) begin
                        beat_n   = '0;
                        result_n = grant_id;
                        state_n  = WAIT_OUT;
                    end else begin
                        beat_n = beat_cnt + CNT_WIDTH'(1);
                    end
                end
            end
            WAIT_OUT: begin
                if (acc_out_valid && acc_out_ready) begin
`ifdef MXINT_ACCUM_ARB_FIXED_PRIO_EN
                    rr_n = '0;
`else
                    rr_n = rr_next;
`endif
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and arbitration registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            grant_id  <= '0;
            result_id <= '0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_n;
            beat_cnt  <= beat_n;
            grant_id  <= grant_n;
            result_id <= result_n;
        end
    end

endmodule

// File: tb/tb_mxint_accum_arbiter.sv
// Bench for mxint_accum_arbiter: requesters offer fixed per-ID data, an
// expected-owner queue is filled when a scenario is launched and drained
// as the accumulator side observes beats and result handshakes.
module tb_mxint_accum_arbiter;

    localparam int NR = 4;
    localparam int P0 = 8;
    localparam int P1 = 4;
    localparam int BS = 4;
    localparam int IN_DEPTH = 2;
`ifdef MXINT_ACCUM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk, rst;
    logic [NR-1:0][BS-1:0][P0-1:0] req_mdata_in;
    logic [NR-1:0][P1-1:0]         req_edata_in;
    logic [NR-1:0]                 req_valid, req_ready;
    logic [BS-1:0][P0-1:0]         acc_mdata;
    logic [P1-1:0]                 acc_edata;
    logic                          acc_valid, acc_ready, acc_out_valid, acc_out_ready;
    logic [1:0]                    result_id, grant_id;
    logic                          busy;

    mxint_accum_arbiter #(
        .NUM_REQ(NR), .DATA_IN_0_PRECISION_0(P0), .DATA_IN_0_PRECISION_1(P1),
        .BLOCK_SIZE(BS), .IN_DEPTH(IN_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_mdata_in(req_mdata_in), .req_edata_in(req_edata_in),
        .req_valid(req_valid), .req_ready(req_ready),
        .acc_mdata(acc_mdata), .acc_edata(acc_edata),
        .acc_valid(acc_valid), .acc_ready(acc_ready),
        .acc_out_valid(acc_out_valid), .acc_out_ready(acc_out_ready),
        .result_id(result_id), .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int left[NR];
    int bcnt, pending, mute_cnt, stall_cnt, gap_req;
    bit stall_arm;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BS-1:0][P0-1:0] exp_m(input int o);
        logic [BS-1:0][P0-1:0] m;
        for (int j = 0; j < BS; j++) m[j] = P0'(16 * o + j + 1);
        return m;
    endfunction

    // One clock: observe at negedge, then drive requesters and the
    // accumulator side just after the posedge.
    task automatic step();
        int o;
        logic [NR-1:0] own;
        @(negedge clk);
        if (!rst) begin
            o   = (exp_q.size() > 0) ? exp_q[0] : -1;
            own = (o >= 0) ? NR'(1 << o) : '0;
            chk("rdy_other", req_ready & ~own, '0);
            if (acc_valid && acc_ready) begin
                if (o < 0) chk("spurious_beat", 1, 0);
                else begin
                    chk("beat_edata", acc_edata, P1'(o + 1));
                    chk("beat_mdata", acc_mdata, exp_m(o));
                    chk("beat_ready", req_ready, own);
                    bcnt++;
                    if (bcnt == IN_DEPTH) pending = 1;
                    if (stall_arm) begin stall_cnt = 3; stall_arm = 0; end
                end
            end
            if (!acc_ready && o >= 0 && bcnt > 0 && pending == 0) begin
                chk("stall_valid", acc_valid, 1);
                chk("stall_edata", acc_edata, P1'(o + 1));
                chk("stall_mdata", acc_mdata, exp_m(o));
            end
            if (gap_req >= 0 && left[gap_req] == 1 && !req_valid[gap_req]) begin
                chk("gap_acc_valid", acc_valid, 0);
                chk("gap_grant", grant_id, gap_req);
            end
            if (acc_out_valid && acc_out_ready && pending != 0) begin
                chk("result_id", result_id, o);
                void'(exp_q.pop_front());
                pending = 0;
                bcnt = 0;
            end
            for (int i = 0; i < NR; i++)
                if (req_valid[i] && req_ready[i]) begin
                    left[i]--;
                    if (i == gap_req && left[i] == 1) mute_cnt = 5;
                end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++)
            req_valid[i] = (left[i] > 0) && !(i == gap_req && mute_cnt > 0);
        if (mute_cnt > 0) mute_cnt--;
        acc_ready = (stall_cnt == 0);
        if (stall_cnt > 0) stall_cnt--;
        if (acc_out_valid) acc_out_valid = 1'b0;
        else if (pending != 0) acc_out_valid = 1'b1;
    endtask

    function automatic bit outstanding();
        int s = 0;
        for (int i = 0; i < NR; i++) s += left[i];
        return (exp_q.size() > 0) || busy || (s > 0);
    endfunction

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (outstanding() && n < budget) begin
            step();
            n++;
        end
        chk(tag, outstanding(), 0);
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; acc_ready = 1'b1;
        acc_out_valid = 1'b0; acc_out_ready = 1'b1;
        bcnt = 0; pending = 0; mute_cnt = 0; stall_cnt = 0; gap_req = -1; stall_arm = 0;
        for (int r = 0; r < NR; r++) begin
            left[r] = 0;
            req_edata_in[r] = P1'(r + 1);
            for (int j = 0; j < BS; j++) req_mdata_in[r][j] = P0'(16 * r + j + 1);
        end

        // reset values
        step(); step();
        chk("rst_req_ready", req_ready, '0);
        chk("rst_acc_valid", acc_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_result", result_id, 0);
        rst = 1'b0;
        step();

        // single requester 2; grant one cycle after valid is seen
        left[2] = 2; exp_q.push_back(2);
        step();
        chk("s1_idle_busy", busy, 0);
        step();
        chk("s1_grant", grant_id, 2);
        chk("s1_busy", busy, 1);
        drain("s1_drain", 100);
        chk("s1_idle_after", busy, 0);

        // 0 and 3: round-robin resumes after 2, so 3 wins first
        left[0] = 2; left[3] = 2;
        if (FIXED) begin exp_q.push_back(0); exp_q.push_back(3); end
        else       begin exp_q.push_back(3); exp_q.push_back(0); end
        drain("s1b_drain", 100);

        // 0 and 3 continuously valid for two accumulations each
        left[0] = 4; left[3] = 4;
        if (FIXED) begin exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(3); end
        else       begin exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(0); end
        drain("s2_drain", 200);

        // granted requester 1 drops valid for 5 cycles after its first beat
        gap_req = 1; left[0] = 2; left[1] = 2;
        if (FIXED) begin exp_q.push_back(0); exp_q.push_back(1); end
        else       begin exp_q.push_back(1); exp_q.push_back(0); end
        drain("s3_drain", 100);
        gap_req = -1;

        // acc_ready low for 3 cycles after the first beat
        stall_arm = 1; left[2] = 2; exp_q.push_back(2);
        drain("s4_drain", 100);
        chk("s4_stall_seen", stall_arm, 0);

        // reset mid-STREAM after one beat
        left[3] = 2; exp_q.push_back(3);
        begin
            int n = 0;
            while (bcnt < 1 && n < 50) begin step(); n++; end
            chk("s5_first_beat", bcnt, 1);
        end
        rst = 1'b1; left[3] = 0;
        step();
        chk("s5_busy", busy, 0);
        chk("s5_req_ready", req_ready, '0);
        chk("s5_acc_valid", acc_valid, 0);
        chk("s5_grant", grant_id, 0);
        exp_q.delete(); bcnt = 0; pending = 0;
        rst = 1'b0;
        step();
        // rr_ptr back at 0: 1 precedes 3
        left[1] = 2; left[3] = 2;
        exp_q.push_back(1); exp_q.push_back(3);
        drain("s5_drain", 100);

        // 0 and 2 continuously valid: alternate, or 0 starves 2 when fixed
        left[0] = 4; left[2] = 4;
        if (FIXED) begin exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(2); end
        else       begin exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(2); end
        drain("s6_drain", 200);
        chk("end_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
